// File: rtl/riscv_mem_issue.sv
// Memory-access stage: registers EX results for WB and issues credit-limited dmem requests.
// Define RV_MEM_MISALIGNED_CHECK_EN to trap misaligned loads/stores locally instead of issuing them.
package riscv_mem_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic        bubble;
    logic [31:0] instr;
  } instruction_t;

  typedef struct packed {
    logic illegal_insn;
    logic breakpoint;
    logic ecall;
    logic misaligned_load;
    logic misaligned_store;
    logic any;
  } interrupts_exceptions_t;
endpackage

module riscv_mem_issue
  import riscv_mem_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PC_INIT         = 'h200,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   wb_stall_i,
  output logic                   mem_stall_o,
  input  logic [XLEN-1:0]        ex_pc_i,
  input  instruction_t           ex_insn_i,
  input  interrupts_exceptions_t ex_exceptions_i,
  input  logic [XLEN-1:0]        ex_r_i,
  input  logic [XLEN-1:0]        ex_memadr_i,
  input  logic [XLEN-1:0]        ex_memdata_i,
  output logic [XLEN-1:0]        mem_pc_o,
  output instruction_t           mem_insn_o,
  output interrupts_exceptions_t mem_exceptions_o,
  output logic [XLEN-1:0]        mem_r_o,
  output logic [XLEN-1:0]        mem_memadr_o,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [XLEN-1:0]        dmem_adr_o,
  output logic [1:0]             dmem_size_o,
  output logic [XLEN-1:0]        dmem_d_o,
  input  logic                   dmem_ack_i,
  input  logic                   dmem_err_i
);
  localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt;
  logic [6:0]    opc;
  logic [1:0]    size;
  logic          is_load, is_store, memop;
  logic          resp, full, blocked, misaligned, resp_ok;
  interrupts_exceptions_t exc_nxt;

  assign opc      = ex_insn_i.instr[6:0];
  assign size     = ex_insn_i.instr[13:12];
  assign is_load  = ~ex_insn_i.bubble & (opc == OPC_LOAD);
  assign is_store = ~ex_insn_i.bubble & (opc == OPC_STORE);
  assign memop    = is_load | is_store;

  // A response in the same cycle frees a slot, so a full counter does not block.
  assign resp    = dmem_ack_i | dmem_err_i;
  assign full    = (cnt == MAX_C) & ~resp;
  assign blocked = memop & full;
  assign resp_ok = resp & (cnt != '0);

  assign mem_stall_o = wb_stall_i | blocked;

  always_comb begin
    misaligned = 1'b0;
`ifdef RV_MEM_MISALIGNED_CHECK_EN
    if (memop) begin
      case (size)
        2'b01:   misaligned = ex_memadr_i[0];
        2'b10:   misaligned = |ex_memadr_i[1:0];
        2'b11:   misaligned = |ex_memadr_i[2:0];
        default: misaligned = 1'b0;
      endcase
    end
`endif
  end

  assign dmem_req_o = ~rst_i & memop & ~flush_i & ~wb_stall_i & ~blocked &
                      ~ex_exceptions_i.any & ~mem_exceptions_o.any & ~misaligned;
  assign dmem_we_o   = is_store;
  assign dmem_adr_o  = ex_memadr_i;
  assign dmem_size_o = size;

  always_comb begin
    dmem_d_o = ex_memdata_i;
    case (size)
      2'b00:   dmem_d_o = {(XLEN/8){ex_memdata_i[7:0]}};
      2'b01:   dmem_d_o = {(XLEN/16){ex_memdata_i[15:0]}};
      2'b10:   dmem_d_o = {(XLEN/32){ex_memdata_i[31:0]}};
      default: dmem_d_o = ex_memdata_i;
    endcase
  end

  always_comb begin
    exc_nxt                  = ex_exceptions_i;
    exc_nxt.misaligned_load  = ex_exceptions_i.misaligned_load  | (misaligned & is_load);
    exc_nxt.misaligned_store = ex_exceptions_i.misaligned_store | (misaligned & is_store);
    exc_nxt.any = exc_nxt.illegal_insn | exc_nxt.breakpoint | exc_nxt.ecall |
                  exc_nxt.misaligned_load | exc_nxt.misaligned_store;
    if (flush_i | blocked) exc_nxt = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_pc_o          <= PC_INIT;
      mem_insn_o.bubble <= 1'b1;
      mem_insn_o.instr  <= '0;
      mem_exceptions_o  <= '0;
      mem_r_o           <= '0;
      mem_memadr_o      <= '0;
    end else if (!wb_stall_i) begin
      mem_pc_o          <= ex_pc_i;
      mem_insn_o.instr  <= ex_insn_i.instr;
      mem_insn_o.bubble <= ex_insn_i.bubble | flush_i | blocked;
      mem_exceptions_o  <= exc_nxt;
      mem_r_o           <= ex_r_i;
      mem_memadr_o      <= ex_memadr_i;
    end
  end

  // Responses with no outstanding credit (e.g. late acks after reset) are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      case ({dmem_req_o, resp_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mem_issue.sv
// Directed scoreboard bench for riscv_mem_issue (XLEN=32, MAX_OUTSTANDING=2).
module tb_riscv_mem_issue;
  import riscv_mem_pkg::*;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   bub;
    interrupts_exceptions_t exc;
    logic [31:0]            r;
    logic [31:0]            adr;
  } exp_t;

  logic clk, rst, flush, wb_stall, mem_stall;
  logic [31:0] ex_pc, ex_r, ex_memadr, ex_memdata;
  instruction_t ex_insn, mem_insn;
  interrupts_exceptions_t ex_exc, mem_exc, e_none, e_ml, e_ill;
  logic [31:0] mem_pc, mem_r, mem_memadr, dmem_adr, dmem_d;
  logic dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [1:0] dmem_size;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  exp_t last;

  riscv_mem_issue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wb_stall_i(wb_stall),
    .mem_stall_o(mem_stall), .ex_pc_i(ex_pc), .ex_insn_i(ex_insn),
    .ex_exceptions_i(ex_exc), .ex_r_i(ex_r), .ex_memadr_i(ex_memadr),
    .ex_memdata_i(ex_memdata), .mem_pc_o(mem_pc), .mem_insn_o(mem_insn),
    .mem_exceptions_o(mem_exc), .mem_r_o(mem_r), .mem_memadr_o(mem_memadr),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_adr_o(dmem_adr),
    .dmem_size_o(dmem_size), .dmem_d_o(dmem_d), .dmem_ack_i(dmem_ack),
    .dmem_err_i(dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic bub, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] adr, input logic [31:0] data);
    ex_insn.bubble = bub;
    ex_insn.instr  = {17'h0, f3, 5'd5, opc};
    ex_pc      = pc;
    ex_r       = pc ^ 32'hA5A5_0000;
    ex_memadr  = adr;
    ex_memdata = data;
    ex_exc     = '0;
    flush      = 1'b0;
    wb_stall   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_err   = 1'b0;
  endtask

  // Checks combinational outputs mid-cycle, then the registered stage against the scoreboard.
  task automatic step(input logic e_req, input logic e_stall, input logic e_bub,
                      input interrupts_exceptions_t e_exc);
    exp_t e;
    @(negedge clk);
    chk("dmem_req", 64'(dmem_req), 64'(e_req));
    chk("mem_stall", 64'(mem_stall), 64'(e_stall));
    if (wb_stall) e = last;
    else e = '{pc: ex_pc, bub: e_bub, exc: e_exc, r: ex_r, adr: ex_memadr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("mem_pc", 64'(mem_pc), 64'(e.pc));
    chk("mem_bubble", 64'(mem_insn.bubble), 64'(e.bub));
    chk("mem_exc", 64'(mem_exc), 64'(e.exc));
    chk("mem_r", 64'(mem_r), 64'(e.r));
    chk("mem_memadr", 64'(mem_memadr), 64'(e.adr));
    last = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req", 64'(dmem_req), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_pc", 64'(mem_pc), 64'h200);
    chk("rst_bubble", 64'(mem_insn.bubble), 64'd1);
    chk("rst_exc", 64'(mem_exc), 64'd0);
    chk("rst_r", 64'(mem_r), 64'd0);
    chk("rst_adr", 64'(mem_memadr), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_cnt", 64'(dut.cnt), 64'd0);
    rst = 1'b0;
    sb.delete();
    last = '{pc: 32'h200, bub: 1'b1, exc: '0, r: '0, adr: '0};
  endtask

  initial begin
    e_none = '0;
    e_ml = '0; e_ml.misaligned_load = 1'b1; e_ml.any = 1'b1;
    e_ill = '0; e_ill.illegal_insn = 1'b1; e_ill.any = 1'b1;
    rst = 1'b1;
    set_ex(1'b1, 7'h0, 3'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    do_reset();

    // LW x5,0x100 acked next cycle
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1000, 32'h100, 32'h0);
    #1;
    chk("lw_size", 64'(dmem_size), 64'd2);
    chk("lw_we", 64'(dmem_we), 64'd0);
    chk("lw_adr", 64'(dmem_adr), 64'h100);
    step(1'b1, 1'b0, 1'b0, e_none);
    chk("lw_cnt1", 64'(dut.cnt), 64'd1);
    set_ex(1'b1, OPC_LOAD, 3'd2, 32'h1004, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    chk("lw_cnt0", 64'(dut.cnt), 64'd0);

    // SB replication, then SH replication
    set_ex(1'b0, OPC_STORE, 3'd0, 32'h1008, 32'h103, 32'h0000_00A5);
    #1;
    chk("sb_d", 64'(dmem_d), 64'hA5A5A5A5);
    chk("sb_we", 64'(dmem_we), 64'd1);
    chk("sb_size", 64'(dmem_size), 64'd0);
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b0, OPC_STORE, 3'd1, 32'h100C, 32'h102, 32'hDEAD_1234);
    dmem_ack = 1'b1;
    #1;
    chk("sh_d", 64'(dmem_d), 64'h12341234);
    chk("sh_size", 64'(dmem_size), 64'd1);
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b1, 7'h0, 3'd0, 32'h1010, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    chk("st_cnt0", 64'(dut.cnt), 64'd0);

    // Three back-to-back loads against two credits
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1100, 32'h200, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1104, 32'h204, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    chk("b2b_cnt2", 64'(dut.cnt), 64'd2);
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1108, 32'h208, 32'h0);
    step(1'b0, 1'b1, 1'b1, e_none);
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1108, 32'h208, 32'h0);
    dmem_ack = 1'b1;
    step(1'b1, 1'b0, 1'b0, e_none);
    chk("b2b_cnt_hold", 64'(dut.cnt), 64'd2);
    set_ex(1'b1, 7'h0, 3'd0, 32'h110C, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    set_ex(1'b1, 7'h0, 3'd0, 32'h1110, 32'h0, 32'h0);
    dmem_err = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    chk("b2b_cnt0", 64'(dut.cnt), 64'd0);

    // LW @0x102
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1200, 32'h102, 32'h0);
`ifdef RV_MEM_MISALIGNED_CHECK_EN
    step(1'b0, 1'b0, 1'b0, e_ml);
    set_ex(1'b1, 7'h0, 3'd0, 32'h1204, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, e_none);
`else
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b1, 7'h0, 3'd0, 32'h1204, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
`endif
    chk("mis_cnt0", 64'(dut.cnt), 64'd0);

    // EX exception suppresses the request; the faulting insn in MEM then blocks the next store
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h1300, 32'h300, 32'h0);
    ex_exc = e_ill;
    step(1'b0, 1'b0, 1'b0, e_ill);
    set_ex(1'b0, OPC_STORE, 3'd2, 32'h1304, 32'h304, 32'h1);
    step(1'b0, 1'b0, 1'b0, e_none);

    // Flush kills a valid SW
    set_ex(1'b0, OPC_STORE, 3'd2, 32'h1400, 32'h400, 32'h55);
    flush = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);

    // WB stall holds the stage for three cycles
    set_ex(1'b0, 7'b0110011, 3'd0, 32'h2000, 32'h123, 32'h0);
    step(1'b0, 1'b0, 1'b0, e_none);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b0, OPC_LOAD, 3'd2, 32'h2004 + 32'(i), 32'h500, 32'h0);
      wb_stall = 1'b1;
      step(1'b0, 1'b1, 1'b0, e_none);
    end
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h2010, 32'h500, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b1, 7'h0, 3'd0, 32'h2014, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);

    // Reset with two outstanding, then a late ack is ignored
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h3000, 32'h600, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h3004, 32'h604, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    chk("pre_rst_cnt", 64'(dut.cnt), 64'd2);
    set_ex(1'b0, OPC_LOAD, 3'd2, 32'h3008, 32'h608, 32'h0);
    do_reset();
    set_ex(1'b1, 7'h0, 3'd0, 32'h300C, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    chk("late_ack_cnt", 64'(dut.cnt), 64'd0);
    set_ex(1'b0, OPC_LOAD, 3'd3, 32'h3010, 32'h610, 32'h0);
    step(1'b1, 1'b0, 1'b0, e_none);
    chk("post_rst_cnt1", 64'(dut.cnt), 64'd1);
    set_ex(1'b1, 7'h0, 3'd0, 32'h3014, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    step(1'b0, 1'b0, 1'b1, e_none);
    chk("post_rst_cnt0", 64'(dut.cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
